// File: rtl/lane_raster_stream_if.sv
// Pixel stream bundle for lane_raster_stream: label pixels in, RGB pixels out.
// master = the environment that feeds labels and drains RGB; slave = the converter.
interface lane_raster_stream_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_label;
  logic        in_sof;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_rgb;
  logic        out_sol;
  logic        out_eol;
  logic        out_eof;

  modport master (
    output in_valid, in_label, in_sof, out_ready,
    input  in_ready, out_valid, out_rgb, out_sol, out_eol, out_eof
  );

  modport slave (
    input  in_valid, in_label, in_sof, out_ready,
    output in_ready, out_valid, out_rgb, out_sol, out_eol, out_eof
  );
endinterface

// File: rtl/lane_raster_stream.sv
// Lane-label to RGB raster converter. Maps each label through a small writable
// palette (binary threshold or per-class lookup), tracks raster position after
// a start-of-frame pixel, and tags the output with line/frame markers.
// One output register; input is ready whenever that register is free or draining.
module lane_raster_stream #(
  parameter int          WIDTH       = 640,
  parameter int          HEIGHT      = 480,
  parameter int          NUM_CLASSES = 4,
  parameter logic [7:0]  LANE_THRESH = 8'hFF,
  parameter logic [23:0] BG_COLOR    = 24'h000000,
  parameter logic [23:0] LANE_COLOR  = 24'hFF0000
) (
  input  logic                 clk,
  input  logic                 reset,
  lane_raster_stream_if.slave  strm,
  input  logic                 mode,
  input  logic                 cfg_we,
  input  logic [7:0]           cfg_addr,
  input  logic [23:0]          cfg_data,
  output logic [15:0]          frame_count,
  output logic                 err_sync,
  input  logic                 err_clr
);

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  // A one-pixel line or frame would make sol/eol/eof ambiguous, so refuse it.
  if (WIDTH < 2) begin : g_bad_width
    $error("lane_raster_stream: WIDTH must be at least 2");
  end
  if (HEIGHT < 2) begin : g_bad_height
    $error("lane_raster_stream: HEIGHT must be at least 2");
  end
  if (NUM_CLASSES < 2 || NUM_CLASSES > 256) begin : g_bad_classes
    $error("lane_raster_stream: NUM_CLASSES must be in 2..256");
  end

  typedef enum logic [0:0] {WAIT_SOF, ACTIVE} state_t;

  state_t          state_reg, state_next;
  logic [XW-1:0]   x_reg, x_next, px_x;
  logic [YW-1:0]   y_reg, y_next, px_y;
  logic            accept, emit, restart, sync_err, frame_done;
  logic            pix_sol, pix_eol, pix_eof;
  logic [23:0]     class_rgb, bin_rgb, pix_rgb;
  logic            out_valid_reg, out_sol_reg, out_eol_reg, out_eof_reg;
  logic [23:0]     out_rgb_reg;
  logic [15:0]     frame_count_reg;
  logic            err_sync_reg;
  logic [23:0]     pal [NUM_CLASSES];

  assign strm.in_ready = !out_valid_reg || strm.out_ready;
  assign accept        = strm.in_valid && strm.in_ready;

  // Palette entries; an address outside the table matches no entry, so the
  // write simply falls on the floor. Readers see the old value until the edge.
  for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_pal
    localparam logic [23:0] RST_COLOR = (gi == 0) ? BG_COLOR : LANE_COLOR;
    logic [23:0] entry_reg;
    // Per-entry write enable decoded from cfg_addr.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        entry_reg <= RST_COLOR;
      else if (cfg_we && cfg_addr == 8'(gi))
        entry_reg <= cfg_data;
    end
    assign pal[gi] = entry_reg;
  end

  // Colour lookup for the pixel on the input bus, using the mode of this cycle.
  always_comb begin
    class_rgb = pal[0];
    for (int i = 1; i < NUM_CLASSES; i++) begin
      if (strm.in_label == 8'(i)) class_rgb = pal[i];
    end
    bin_rgb = (strm.in_label >= LANE_THRESH) ? pal[1] : pal[0];
    pix_rgb = mode ? class_rgb : bin_rgb;
  end

  // Raster FSM: decide whether the accepted pixel is emitted, where it sits,
  // and where the next one will sit. A sof pixel always restarts at (0,0).
  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    emit       = 1'b0;
    restart    = 1'b0;
    sync_err   = 1'b0;
    frame_done = 1'b0;
    px_x       = x_reg;
    px_y       = y_reg;
    if (accept) begin
      case (state_reg)
        WAIT_SOF: begin
          if (strm.in_sof) begin
            emit    = 1'b1;
            restart = 1'b1;
          end
        end
        ACTIVE: begin
          emit = 1'b1;
          if (strm.in_sof) begin
            restart = 1'b1;
            if (x_reg != '0 || y_reg != '0) sync_err = 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (restart) begin
      px_x = '0;
      px_y = '0;
    end
    pix_sol = (px_x == '0);
    pix_eol = (px_x == X_LAST);
    pix_eof = pix_eol && (px_y == Y_LAST);
    if (emit) begin
      if (pix_eof) begin
        state_next = WAIT_SOF;
        x_next     = '0;
        y_next     = '0;
        frame_done = 1'b1;
      end else begin
        state_next = ACTIVE;
        if (pix_eol) begin
          x_next = '0;
          y_next = px_y + 1'b1;
        end else begin
          x_next = px_x + 1'b1;
          y_next = px_y;
        end
      end
    end
  end

  // Raster state and position registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= WAIT_SOF;
      x_reg     <= '0;
      y_reg     <= '0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
    end
  end

  // Output register: load on emit, hold while stalled, empty once drained.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_rgb_reg   <= '0;
      out_sol_reg   <= 1'b0;
      out_eol_reg   <= 1'b0;
      out_eof_reg   <= 1'b0;
    end else if (emit) begin
      out_valid_reg <= 1'b1;
      out_rgb_reg   <= pix_rgb;
      out_sol_reg   <= pix_sol;
      out_eol_reg   <= pix_eol;
      out_eof_reg   <= pix_eof;
    end else if (strm.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Completed-frame counter (wraps) and sticky sync error where set beats clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count_reg <= '0;
      err_sync_reg    <= 1'b0;
    end else begin
      if (frame_done) frame_count_reg <= frame_count_reg + 16'd1;
      if (sync_err)
        err_sync_reg <= 1'b1;
      else if (err_clr)
        err_sync_reg <= 1'b0;
    end
  end

  assign strm.out_valid = out_valid_reg;
  assign strm.out_rgb   = out_rgb_reg;
  assign strm.out_sol   = out_sol_reg;
  assign strm.out_eol   = out_eol_reg;
  assign strm.out_eof   = out_eof_reg;
  assign frame_count    = frame_count_reg;
  assign err_sync       = err_sync_reg;

endmodule

// File: tb/tb_lane_raster_stream.sv
// Directed bench for lane_raster_stream (4x2 frames, 4 classes). Expected
// pixels are queued as stimulus is accepted and checked as they leave.
module tb_lane_raster_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic        mode;
  logic        cfg_we;
  logic [7:0]  cfg_addr;
  logic [23:0] cfg_data;
  logic [15:0] frame_count;
  logic        err_sync;
  logic        err_clr;

  lane_raster_stream_if bus ();

  lane_raster_stream #(
    .WIDTH(4), .HEIGHT(2), .NUM_CLASSES(4)
  ) dut (
    .clk(clk), .reset(reset), .strm(bus), .mode(mode),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .frame_count(frame_count), .err_sync(err_sync), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] rgb;
    logic        sol;
    logic        eol;
    logic        eof;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every output transfer must match the oldest queued pixel.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      chk("out_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        $display("out rgb=%06h sol=%0b eol=%0b eof=%0b", bus.out_rgb, bus.out_sol, bus.out_eol, bus.out_eof);
        chk("out_rgb", 32'(bus.out_rgb), 32'(e.rgb));
        chk("out_marks", 32'({bus.out_sol, bus.out_eol, bus.out_eof}), 32'({e.sol, e.eol, e.eof}));
      end
    end
  end

  // Offer one pixel; queue its expected output (if any) when it is accepted.
  task automatic px(input logic [7:0] lab, input logic sof, input logic md, input logic emit,
                    input logic [23:0] rgb, input logic sol, input logic eol, input logic eof);
    logic done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_label = lab;
    bus.in_sof   = sof;
    mode         = md;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        if (emit) exp_q.push_back({rgb, sol, eol, eof});
        done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [7:0] a, input logic [23:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mode = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; err_clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_label = '0; bus.in_sof = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_rgb", 32'(bus.out_rgb), 32'd0);
    chk("rst_marks", 32'({bus.out_sol, bus.out_eol, bus.out_eof}), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_err_sync", 32'(err_sync), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Pixels before any sof are swallowed.
    px(8'h00, 0, 0, 0, 24'h0, 0, 0, 0);
    px(8'hFF, 0, 0, 0, 24'h0, 0, 0, 0);
    px(8'h07, 0, 0, 0, 24'h0, 0, 0, 0);
    // Binary frame.
    px(8'hFF, 1, 0, 1, 24'hFF0000, 1, 0, 0);
    px(8'h00, 0, 0, 1, 24'h000000, 0, 0, 0);
    px(8'hFE, 0, 0, 1, 24'h000000, 0, 0, 0);
    px(8'hFF, 0, 0, 1, 24'hFF0000, 0, 1, 0);
    px(8'hFF, 0, 0, 1, 24'hFF0000, 1, 0, 0);
    px(8'hFE, 0, 0, 1, 24'h000000, 0, 0, 0);
    px(8'h00, 0, 0, 1, 24'h000000, 0, 0, 0);
    px(8'hFF, 0, 0, 1, 24'hFF0000, 0, 1, 1);
    idle(3);
    chk("frame_count_1", 32'(frame_count), 32'd1);
    chk("drain_1", 32'(exp_q.size()), 32'd0);

    // Class frame with a mid-frame switch back to binary on the last pixel.
    cfg(8'd2, 24'h00FF00);
    px(8'd2, 1, 1, 1, 24'h00FF00, 1, 0, 0);
    px(8'd3, 0, 1, 1, 24'hFF0000, 0, 0, 0);
    px(8'd0, 0, 1, 1, 24'h000000, 0, 0, 0);
    px(8'd7, 0, 1, 1, 24'h000000, 0, 1, 0);
    px(8'd1, 0, 1, 1, 24'hFF0000, 1, 0, 0);
    px(8'd2, 0, 1, 1, 24'h00FF00, 0, 0, 0);
    px(8'd4, 0, 1, 1, 24'h000000, 0, 0, 0);
    px(8'hFF, 0, 0, 1, 24'hFF0000, 0, 1, 1);
    idle(3);
    chk("frame_count_2", 32'(frame_count), 32'd2);

    // Palette write in the same cycle as a pixel: that pixel sees the old colour.
    cfg_we = 1'b1; cfg_addr = 8'd3; cfg_data = 24'h0000FF;
    px(8'd3, 1, 1, 1, 24'hFF0000, 1, 0, 0);
    cfg_we = 1'b0;
    px(8'd3, 0, 1, 1, 24'h0000FF, 0, 0, 0);
    px(8'd2, 0, 1, 1, 24'h00FF00, 0, 0, 0);
    // Three stalled cycles with a pixel waiting.
    fork
      px(8'd1, 0, 1, 1, 24'hFF0000, 0, 1, 0);
      begin
        bus.out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_rgb", 32'(bus.out_rgb), 32'h00FF00);
          chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    px(8'd0, 0, 1, 1, 24'h0, 1, 0, 0);
    px(8'd0, 0, 1, 1, 24'h0, 0, 0, 0);
    px(8'd0, 0, 1, 1, 24'h0, 0, 0, 0);
    px(8'd0, 0, 1, 1, 24'h0, 0, 1, 1);
    idle(3);
    chk("frame_count_3", 32'(frame_count), 32'd3);

    // sof at (2,1): restart without eof.
    px(8'hFF, 1, 0, 1, 24'hFF0000, 1, 0, 0);
    px(8'h00, 0, 0, 1, 24'h0, 0, 0, 0);
    px(8'h00, 0, 0, 1, 24'h0, 0, 0, 0);
    px(8'h00, 0, 0, 1, 24'h0, 0, 1, 0);
    px(8'h00, 0, 0, 1, 24'h0, 1, 0, 0);
    px(8'h00, 0, 0, 1, 24'h0, 0, 0, 0);
    px(8'hFF, 1, 0, 1, 24'hFF0000, 1, 0, 0);
    idle(2);
    chk("err_sync_set", 32'(err_sync), 32'd1);
    chk("frame_count_trunc", 32'(frame_count), 32'd3);
    px(8'h00, 0, 0, 1, 24'h0, 0, 0, 0);
    px(8'h00, 0, 0, 1, 24'h0, 0, 0, 0);
    px(8'h00, 0, 0, 1, 24'h0, 0, 1, 0);
    px(8'h00, 0, 0, 1, 24'h0, 1, 0, 0);
    px(8'h00, 0, 0, 1, 24'h0, 0, 0, 0);
    px(8'h00, 0, 0, 1, 24'h0, 0, 0, 0);
    px(8'hFF, 0, 0, 1, 24'hFF0000, 0, 1, 1);
    idle(3);
    chk("frame_count_4", 32'(frame_count), 32'd4);
    chk("err_sync_sticky", 32'(err_sync), 32'd1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("err_sync_clr", 32'(err_sync), 32'd0);

    // Set and clear in the same cycle: set wins.
    px(8'hFF, 1, 0, 1, 24'hFF0000, 1, 0, 0);
    px(8'h00, 0, 0, 1, 24'h0, 0, 0, 0);
    err_clr = 1'b1;
    px(8'hFF, 1, 0, 1, 24'hFF0000, 1, 0, 0);
    err_clr = 1'b0;
    idle(1);
    chk("err_set_wins", 32'(err_sync), 32'd1);
    chk("frame_count_5", 32'(frame_count), 32'd4);

    // Out-of-range palette write is ignored.
    cfg(8'd9, 24'h123456);
    px(8'd1, 0, 1, 1, 24'hFF0000, 0, 0, 0);
    px(8'd2, 0, 1, 1, 24'h00FF00, 0, 0, 0);
    // Reset with a pixel held in the output register.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    chk("held_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_frame_count", 32'(frame_count), 32'd0);
    chk("midrst_err_sync", 32'(err_sync), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    bus.out_ready = 1'b1;

    // After reset a sof is needed again, and the palette is back to defaults.
    px(8'd2, 0, 1, 0, 24'h0, 0, 0, 0);
    px(8'd2, 1, 1, 1, 24'hFF0000, 1, 0, 0);
    px(8'd3, 0, 1, 1, 24'hFF0000, 0, 0, 0);
    idle(4);
    chk("drain_final", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lane_raster_stream.md
LANE_RASTER_STREAM -- requirements
Module: lane_raster_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 640, meaning active pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 480, meaning active lines per frame.
REQ-003 SHALL have parameter NUM_CLASSES, default 4, meaning the number of palette entries (2..256); entry 0 is background.
REQ-004 SHALL have parameter LANE_THRESH, default 8'hFF, meaning the binary-mode lane threshold.
REQ-005 SHALL have parameter BG_COLOR, default 24'h000000, meaning the reset value of palette entry 0.
REQ-006 SHALL have parameter LANE_COLOR, default 24'hFF0000, meaning the reset value of palette entries 1..NUM_CLASSES-1.
REQ-007 SHALL have ports clk in 1 (clock), and reset in 1, asynchronous, active-high.
REQ-008 SHALL have ports in_valid in 1, in_ready out 1, in_label in 8, in_sof in 1, meaning a raster-order lane-label pixel stream with a start-of-frame marker.
REQ-009 SHALL have ports out_valid out 1, out_ready in 1, out_rgb out 24, out_sol out 1, out_eol out 1, out_eof out 1, meaning an RGB pixel stream with line and frame markers.
REQ-010 SHALL have ports mode in 1 (0 = binary, 1 = class), cfg_we in 1, cfg_addr in 8, cfg_data in 24, meaning the palette write port.
REQ-011 SHALL have ports frame_count out 16, err_sync out 1 (sticky), err_clr in 1.

Function
REQ-012 SHALL accept an input pixel when in_valid && in_ready; in_ready = !out_valid || out_ready, giving a single output register with no bubble at full throughput.
REQ-013 SHALL present an accepted pixel on out_* in the cycle after acceptance (latency 1), and SHALL hold out_* stable while out_valid && !out_ready.
REQ-014 SHALL map binary mode as in_label >= LANE_THRESH -> palette[1], else palette[0].
REQ-015 SHALL map class mode as in_label in 1..NUM_CLASSES-1 -> palette[in_label]; 0 or >= NUM_CLASSES -> palette[0].
REQ-016 SHALL sample mode per accepted pixel, so a mode change is allowed mid-frame.
REQ-017 SHALL write cfg_data into palette[cfg_addr] on a cfg_we cycle; writes with cfg_addr >= NUM_CLASSES are ignored.
REQ-018 SHALL NOT let a palette write affect a pixel accepted in the same cycle; a pixel accepted in the next cycle sees the new value.
REQ-019 SHALL implement FSM WAIT_SOF / ACTIVE, with reset state WAIT_SOF.
REQ-020 In WAIT_SOF, SHALL accept and discard pixels with in_sof=0 (no output), keeping in_ready driven per REQ-012.
REQ-021 In WAIT_SOF, a pixel with in_sof=1 SHALL become pixel (0,0), be emitted, and move the FSM to ACTIVE.
REQ-022 In ACTIVE, SHALL keep counters x (0..WIDTH-1) and y (0..HEIGHT-1), advancing x per accepted pixel and wrapping x to 0 with y+1.
REQ-023 SHALL set out_sol when x==0, out_eol when x==WIDTH-1, and out_eof when x==WIDTH-1 && y==HEIGHT-1.
REQ-024 On acceptance of the eof pixel, SHALL increment frame_count (wrapping 16'hFFFF -> 0) and return the FSM to WAIT_SOF.
REQ-025 In ACTIVE, an in_sof=1 pixel at (x,y) != (0,0) SHALL set err_sync, restart the pixel as (0,0) of a new frame without emitting eof for the truncated frame, and leave frame_count unchanged.
REQ-026 err_clr SHALL clear err_sync; if a set and a clear occur in the same cycle, set wins.
REQ-027 SHALL use ceil(log2) widths for x and y, and SHALL reject WIDTH or HEIGHT < 2 by elaboration error.

Reset
REQ-028 Reset SHALL drive out_valid=0, out_rgb=0, out_sol=0, out_eol=0, out_eof=0, frame_count=0, err_sync=0, x=y=0, FSM=WAIT_SOF.
REQ-029 Reset SHALL restore the palette to BG_COLOR / LANE_COLOR.
REQ-030 Reset mid-frame SHALL discard the in-flight output pixel; the next frame requires in_sof.

Verification
REQ-031 Binary mode, WIDTH=4, HEIGHT=2, labels FF,00,FE,FF with sof on the first -> out_rgb FF0000,000000,000000,FF0000; eol on pixels 4 and 8; eof on pixel 8; frame_count=1.
REQ-032 Class mode, NUM_CLASSES=4, palette[2]=00FF00 written, labels 2,3,0,7 -> 00FF00, FF0000, 000000, 000000.
REQ-033 out_ready low for 3 cycles mid-line with continuous in_valid -> out_rgb held, in_ready=0, no pixel lost or duplicated.
REQ-034 Three pixels without sof after reset -> no out_valid; the following sof pixel emits with out_sol=1.
REQ-035 sof at (2,1) -> err_sync=1, no eof emitted, frame_count unchanged, next outputs start at x=0; err_clr -> err_sync=0.
REQ-036 cfg_we with cfg_addr=9 on NUM_CLASSES=4 -> palette unchanged; reset asserted mid-frame -> out_valid=0 the next cycle.
